// File: rtl/rf_wb_arbiter_pkg.sv
`timescale 1ns/1ps
// rf_wb_arbiter_pkg: shared widths, writeback source tags and the hazard
// compare helper used by the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   localparam int XLEN      = 32;
   localparam int RF_ADDR_W = 5;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [XLEN-1:0]      rf_data_t;

   // Which source drives the register-file write port this cycle.
   typedef enum logic {
      WBSRC_A = 1'b0,
      WBSRC_B = 1'b1
   } wb_src_e;

   // True when a queued destination collides with either decode operand.
   // Register 0 is hardwired, so it never produces a hazard.
   function automatic logic rd_hits(input rf_addr_t rd,
                                    input rf_addr_t rs1,
                                    input rf_addr_t rs2);
      return (rd != '0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
`timescale 1ns/1ps
// rf_wb_fifo: DEPTH-entry circular buffer of {live, rd, data} for the
// long-latency writeback source. Pointers carry one extra bit so full and
// empty can be told apart when the index bits match. Entries can be killed
// by destination register (WAW against a newer in-order write); a killed
// entry still occupies its slot and is popped without writing.
module rf_wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  rf_addr_t              push_rd,
   input  rf_data_t              push_data,
   input  logic                  pop,
   input  logic                  kill_en,
   input  rf_addr_t              kill_rd,
   output logic                  full,
   output logic                  empty,
   output logic                  head_live,
   output rf_addr_t              head_rd,
   output rf_data_t              head_data,
   output logic [DEPTH-1:0]      ent_live,
   output rf_addr_t [DEPTH-1:0]  ent_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

   logic [PTR_W:0]       wptr_q, wptr_d;
   logic [PTR_W:0]       rptr_q, rptr_d;
   logic [DEPTH-1:0]     live_q, live_d;
   rf_addr_t [DEPTH-1:0] rd_q, rd_d;
   rf_data_t             data_q [DEPTH];
   rf_data_t             data_d [DEPTH];

   logic [PTR_W-1:0]     head_idx;
   logic [PTR_W-1:0]     tail_idx;
   logic                 push_ok;
   logic                 pop_ok;

   assign head_idx  = rptr_q[PTR_W-1:0];
   assign tail_idx  = wptr_q[PTR_W-1:0];
   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (tail_idx == head_idx);
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;

   assign head_live = live_q[head_idx];
   assign head_rd   = rd_q[head_idx];
   assign head_data = data_q[head_idx];
   assign ent_live  = live_q;
   assign ent_rd    = rd_q;

   // Next-state for pointers and entries: kill first, then pop, then push,
   // so a push into a slot always leaves that slot live.
   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that
      // skips an assignment would otherwise infer a latch.
      live_d = live_q;
      rd_d   = rd_q;
      data_d = data_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;

      if (kill_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_q[i] == kill_rd) begin
               live_d[i] = 1'b0;
            end
         end
      end

      if (pop_ok) begin
         live_d[head_idx] = 1'b0;
         rptr_d           = rptr_q + PTR_ONE;
      end

      if (push_ok) begin
         live_d[tail_idx] = 1'b1;
         rd_d[tail_idx]   = push_rd;
         data_d[tail_idx] = push_data;
         wptr_d           = wptr_q + PTR_ONE;
      end
   end

   // Control state: pointers and live bits, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values regardless of statement order.
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         live_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         live_q <= live_d;
      end
   end

   // Payload storage: rd and data are only meaningful while live is set.
   always_ff @(posedge clk) begin
      // NOTE: the payload array has no reset; the live bits and pointers
      // already mark every slot invalid, so resetting it would only cost area.
      rd_q   <= rd_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
`timescale 1ns/1ps
// rf_wb_arbiter: shares the single register-file write port between the
// in-order WB stage (source A, priority, no backpressure) and a queued
// long-latency source B (ready/valid into rf_wb_fifo). Also reports RAW
// hazards against queued destinations and asks the pipeline to stall when
// the queue head has been starved too long.
// Optional build macro WB_BYPASS_EN: a source-B write skips the empty queue
// and reaches the RF one cycle earlier when source A is not writing.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_valid,
   input  logic [RF_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 ll_valid,
   output logic                 ll_ready,
   input  logic [RF_ADDR_W-1:0] ll_rd,
   input  logic [XLEN-1:0]      ll_data,
   input  logic [RF_ADDR_W-1:0] q_rs1,
   input  logic [RF_ADDR_W-1:0] q_rs2,
   output logic                 q_hazard,
   output logic                 wb_stall,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]      rf_wdata
);

   localparam int              CNT_W   = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Arbitration decisions.
   logic                 a_win;
   logic                 ll_take;
   logic                 bypass;
   logic                 push;
   logic                 pop;
   wb_src_e              src;

   // Queue status.
   logic                 full;
   logic                 empty;
   logic                 head_live;
   rf_addr_t             head_rd;
   rf_data_t             head_data;
   logic [DEPTH-1:0]     ent_live;
   rf_addr_t [DEPTH-1:0] ent_rd;

   // Registered outputs and starvation counter.
   logic                 rf_we_q, rf_we_d;
   rf_addr_t             rf_waddr_q, rf_waddr_d;
   rf_data_t             rf_wdata_q, rf_wdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   rf_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_rd   (ll_rd),
      .push_data (ll_data),
      .pop       (pop),
      .kill_en   (a_win),
      .kill_rd   (wb_rd),
      .full      (full),
      .empty     (empty),
      .head_live (head_live),
      .head_rd   (head_rd),
      .head_data (head_data),
      .ent_live  (ent_live),
      .ent_rd    (ent_rd)
   );

   assign ll_ready = !full;
   assign wb_stall = (cnt_q >= CNT_MAX);

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

   // Decide who owns the write port: A if it writes a real register,
   // otherwise the queue head; x0 writes from B are accepted and dropped.
   always_comb begin
      a_win   = wb_valid && (wb_rd != '0);
      ll_take = ll_valid && !full && (ll_rd != '0);
`ifdef WB_BYPASS_EN
      bypass  = ll_take && empty && !a_win;
`else
      bypass  = 1'b0;
`endif
      pop     = !a_win && !empty;
      push    = ll_take && !bypass;
      src     = a_win ? WBSRC_A : WBSRC_B;
   end

   // Next RF write; address and data hold unless a live write is issued.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;

      case (src)
         WBSRC_A: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
         end
         WBSRC_B: begin
            if (pop) begin
               rf_we_d = head_live;
               if (head_live) begin
                  rf_waddr_d = head_rd;
                  rf_wdata_d = head_data;
               end
            end else if (bypass) begin
               rf_we_d    = 1'b1;
               rf_waddr_d = ll_rd;
               rf_wdata_d = ll_data;
            end
         end
         default: begin
            rf_we_d = 1'b0;
         end
      endcase
   end

   // Starvation: count cycles a waiting head is passed over, saturating.
   always_comb begin
      cnt_d = '0;
      if (!empty && !pop) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end
   end

   // RAW hazard: any live queued destination matching a decode operand.
   always_comb begin
      q_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_live[i] && rd_hits(ent_rd[i], q_rs1, q_rs2)) begin
            q_hazard = 1'b1;
         end
      end
   end

   // Output registers and starvation counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         cnt_q      <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
`timescale 1ns/1ps
// tb_rf_wb_arbiter: directed stimulus with a queue-based reference model of
// the writeback port; a negedge process compares every output each cycle and
// the stimulus adds hand-computed expectations at the interesting points.
module tb_rf_wb_arbiter;
   import rf_wb_arbiter_pkg::*;

   localparam int DEPTH      = 4;
   localparam int STARVE_LIM = 8;
`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 wb_valid;
   logic [RF_ADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]      wb_data;
   logic                 ll_valid;
   logic                 ll_ready;
   logic [RF_ADDR_W-1:0] ll_rd;
   logic [XLEN-1:0]      ll_data;
   logic [RF_ADDR_W-1:0] q_rs1;
   logic [RF_ADDR_W-1:0] q_rs2;
   logic                 q_hazard;
   logic                 wb_stall;
   logic                 rf_we;
   logic [RF_ADDR_W-1:0] rf_waddr;
   logic [XLEN-1:0]      rf_wdata;

   rf_wb_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .ll_valid (ll_valid),
      .ll_ready (ll_ready),
      .ll_rd    (ll_rd),
      .ll_data  (ll_data),
      .q_rs1    (q_rs1),
      .q_rs2    (q_rs2),
      .q_hazard (q_hazard),
      .wb_stall (wb_stall),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          live;
   } ent_t;

   ent_t        mq[$];
   ent_t        m_head;
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_cnt;
   bit          m_a_w, m_acc, m_was_empty, m_popped, m_byp;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_we   = 1'b0;
         m_addr = '0;
         m_data = '0;
         m_cnt  = 0;
      end else begin
         m_a_w       = wb_valid && (wb_rd != 0);
         m_acc       = ll_valid && (mq.size() < DEPTH) && (ll_rd != 0);
         m_was_empty = (mq.size() == 0);
         m_popped    = 1'b0;
         m_byp       = 1'b0;
         m_we        = 1'b0;
         if (m_a_w) begin
            m_we   = 1'b1;
            m_addr = wb_rd;
            m_data = wb_data;
            foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 1'b0;
         end else if (!m_was_empty) begin
            m_head   = mq.pop_front();
            m_popped = 1'b1;
            if (m_head.live) begin
               m_we   = 1'b1;
               m_addr = m_head.rd;
               m_data = m_head.data;
            end
         end else if (BYPASS && m_acc) begin
            m_we   = 1'b1;
            m_addr = ll_rd;
            m_data = ll_data;
            m_byp  = 1'b1;
         end
         if (m_acc && !m_byp) mq.push_back('{rd: ll_rd, data: ll_data, live: 1'b1});
         if (!m_was_empty && !m_popped) m_cnt = (m_cnt < STARVE_LIM) ? m_cnt + 1 : m_cnt;
         else                           m_cnt = 0;
      end
   end

   function automatic bit model_hazard(input logic [4:0] a, input logic [4:0] b);
      bit h = 1'b0;
      foreach (mq[i]) if (mq[i].live && mq[i].rd != 0 && (mq[i].rd == a || mq[i].rd == b)) h = 1'b1;
      return h;
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         check("cyc_rf_we",    rf_we,    m_we);
         check("cyc_rf_waddr", rf_waddr, m_addr);
         check("cyc_rf_wdata", rf_wdata, m_data);
         check("cyc_ll_ready", ll_ready, mq.size() < DEPTH);
         check("cyc_wb_stall", wb_stall, m_cnt >= STARVE_LIM);
         check("cyc_q_hazard", q_hazard, model_hazard(q_rs1, q_rs2));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input bit v, input logic [4:0] rd, input logic [31:0] d);
      wb_valid = v;
      wb_rd    = rd;
      wb_data  = d;
   endtask

   task automatic drive_b(input bit v, input logic [4:0] rd, input logic [31:0] d);
      ll_valid = v;
      ll_rd    = rd;
      ll_data  = d;
   endtask

   task automatic idle();
      drive_a(1'b0, 5'd0, 32'h0);
      drive_b(1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      idle();
      q_rs1 = '0;
      q_rs2 = '0;
      rst   = 1'b0;
      repeat (2) tick();
      check("rst_rf_we",    rf_we,    0);
      check("rst_rf_waddr", rf_waddr, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_ll_ready", ll_ready, 1);
      check("rst_wb_stall", wb_stall, 0);
      rst = 1'b1;
      tick();

      // Source A only.
      drive_a(1'b1, 5'd5, 32'h11);
      tick();
      check("a_we",   rf_we,    1);
      check("a_addr", rf_waddr, 5);
      check("a_data", rf_wdata, 32'h11);
      drive_a(1'b1, 5'd0, 32'h22);
      tick();
      check("a_rd0_we",        rf_we,    0);
      check("a_rd0_hold_addr", rf_waddr, 5);
      check("a_rd0_hold_data", rf_wdata, 32'h11);
      idle();
      tick();

      // Fill the queue while A owns the port every cycle.
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 5'd1, 32'h100 + i);
         drive_b(1'b1, 5'(10 + i), 32'hB0 + i);
         tick();
      end
      check("fill_ll_ready", ll_ready, 0);
      drive_b(1'b1, 5'd14, 32'hEE);
      repeat (4) tick();
      check("starve_below_lim", wb_stall, 0);
      tick();
      check("starve_at_lim", wb_stall, 1);
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("drain_we",   rf_we,    1);
         check("drain_addr", rf_waddr, 10 + i);
         check("drain_data", rf_wdata, 32'hB0 + i);
      end
      check("drain_stall_clear", wb_stall, 0);
      tick();
      check("drain_done_we",    rf_we,    0);
      check("drain_done_ready", ll_ready, 1);

      // WAW kill.
      drive_a(1'b1, 5'd2, 32'h2);
      drive_b(1'b1, 5'd7, 32'hAA);
      tick();
      drive_a(1'b1, 5'd7, 32'hBB);
      drive_b(1'b0, 5'd0, 32'h0);
      q_rs1 = 5'd7;
      #1;
      check("waw_hazard_before", q_hazard, 1);
      tick();
      check("waw_a_we",         rf_we,    1);
      check("waw_a_addr",       rf_waddr, 7);
      check("waw_a_data",       rf_wdata, 32'hBB);
      check("waw_hazard_after", q_hazard, 0);
      idle();
      q_rs1 = 5'd0;
      tick();
      check("waw_dead_pop_we",   rf_we,    0);
      check("waw_dead_pop_data", rf_wdata, 32'hBB);
      // Same-cycle push of the same rd is younger and survives.
      drive_a(1'b1, 5'd7, 32'hCC);
      drive_b(1'b1, 5'd7, 32'hDD);
      tick();
      check("waw_same_a_data", rf_wdata, 32'hCC);
      idle();
      tick();
      check("waw_same_b_we",   rf_we,    1);
      check("waw_same_b_data", rf_wdata, 32'hDD);

      // Hazard query.
      drive_a(1'b1, 5'd1, 32'h1);
      drive_b(1'b1, 5'd3, 32'h33);
      tick();
      drive_b(1'b0, 5'd0, 32'h0);
      q_rs1 = 5'd0;
      q_rs2 = 5'd3;
      #1;
      check("hz_rs2_match", q_hazard, 1);
      q_rs2 = 5'd0;
      #1;
      check("hz_rs_zero", q_hazard, 0);
      q_rs1 = 5'd5;
      q_rs2 = 5'd6;
      #1;
      check("hz_no_match", q_hazard, 0);
      q_rs1 = 5'd0;
      q_rs2 = 5'd3;
      idle();
      tick();
      check("hz_pop_data", rf_wdata, 32'h33);
      check("hz_drained",  q_hazard, 0);
      q_rs2 = 5'd0;

      // x0 from source B is accepted and dropped.
      drive_b(1'b1, 5'd0, 32'h99);
      tick();
      check("b_rd0_we_n1", rf_we, 0);
      idle();
      tick();
      check("b_rd0_we_n2", rf_we, 0);

      // Idle-path latency for source B.
      drive_b(1'b1, 5'd9, 32'h5);
      tick();
      idle();
      check("byp_we_n1", rf_we, BYPASS);
      tick();
      check("byp_we_n2", rf_we, !BYPASS);
      check("byp_addr",  rf_waddr, 9);
      check("byp_data",  rf_wdata, 32'h5);
      tick();

      // Reset with three writes queued.
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 5'd1, 32'h300 + i);
         drive_b(1'b1, 5'(20 + i), 32'h400 + i);
         tick();
      end
      idle();
      q_rs1 = 5'd20;
      #1;
      check("rstq_hazard_before", q_hazard, 1);
      rst = 1'b0;
      #1;
      check("rstq_we",     rf_we,    0);
      check("rstq_ready",  ll_ready, 1);
      check("rstq_stall",  wb_stall, 0);
      check("rstq_hazard", q_hazard, 0);
      tick();
      rst   = 1'b1;
      q_rs1 = 5'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rstq_no_write", rf_we, 0);
      end

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
